// File: rtl/ntt_pkg.sv
// ntt_pkg: shared types and elaboration-time helpers for the iterative NTT engine.
//   clog2 / bitrev   : index arithmetic
//   modred / modmul / modadd / modsub : modular arithmetic on 64-bit carriers
//                      (operands must be < 2^32 so products fit in 64 bits)
//   twiddle          : root^e mod q, used to build twiddle ROMs at elaboration
//   state_e          : engine FSM states
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BFLY  = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  // Reverse the low 'bits' bits of idx.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) r = (r << 1) | ((idx >> i) & 32'd1);
    return r;
  endfunction

  function automatic logic [63:0] modred(input logic [63:0] x, input logic [63:0] q);
    return x % q;
  endfunction

  function automatic logic [63:0] modmul(input logic [63:0] x, input logic [63:0] y,
                                         input logic [63:0] q);
    return (x * y) % q;
  endfunction

  // Inputs already < q.
  function automatic logic [63:0] modadd(input logic [63:0] x, input logic [63:0] y,
                                         input logic [63:0] q);
    logic [63:0] s;
    s = x + y;
    return (s >= q) ? s - q : s;
  endfunction

  // Inputs already < q; a negative difference wraps by adding q.
  function automatic logic [63:0] modsub(input logic [63:0] x, input logic [63:0] y,
                                         input logic [63:0] q);
    return (x >= y) ? x - y : x + q - y;
  endfunction

  function automatic logic [63:0] twiddle(input int unsigned e, input int unsigned root,
                                          input int unsigned q);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < e; i++) r = modmul(r, 64'(root), 64'(q));
    return r;
  endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// ntt_butterfly: combinational Cooley-Tukey butterfly over Z_Q.
//   x, y, t : operands (all < Q), t is the twiddle
//   sum_c   : (x + y*t) mod Q
//   diff_c  : (x - y*t) mod Q
module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter int unsigned N = 17,
  parameter int unsigned Q = 65537
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] t,
  output logic [N-1:0] sum_c,
  output logic [N-1:0] diff_c
);

  logic [63:0] yt_c;

  always_comb begin
    yt_c   = modmul(64'(y), 64'(t), 64'(Q));
    sum_c  = N'(modadd(64'(x), yt_c, 64'(Q)));
    diff_c = N'(modsub(64'(x), yt_c, 64'(Q)));
  end

endmodule

// File: rtl/ntt_iter.sv
// ntt_iter: iterative forward/inverse NTT over Z_Q, one butterfly per cycle.
//   clk, rst          : clock, synchronous active-high reset
//   mode              : 0 forward, 1 inverse (latched on accept)
//   in_valid/in_ready : input handshake for a (D words of N bits)
//   out_valid/out_ready : output handshake for b (natural order, words < Q)
module ntt_iter
  import ntt_pkg::*;
#(
  parameter int unsigned N     = 17,
  parameter int unsigned D     = 16,
  parameter int unsigned Q     = 65537,
  parameter int unsigned W     = 4,
  parameter int unsigned W_INV = 49153,
  parameter int unsigned D_INV = 61441
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*D-1:0] a,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*D-1:0] b
);

  localparam int unsigned LOG_D = clog2(D);
  localparam int unsigned HALF  = D / 2;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [LOG_D-1:0]   s_q, s_d;
  logic [LOG_D-1:0]   k_q, k_d;
  logic [N-1:0]       arr_q [D];
  logic [N-1:0]       arr_d [D];
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [N-1:0]       tw_fwd [HALF];
  logic [N-1:0]       tw_inv [HALF];

  logic [LOG_D-1:0]   h_c, j_c, jh_c, e_c;
  logic [N-1:0]       t_c, sum_c, diff_c;

  // Twiddle ROMs, constant at elaboration.
  for (genvar g = 0; g < HALF; g++) begin : g_rom
    assign tw_fwd[g] = N'(twiddle(g, W, Q));
    assign tw_inv[g] = N'(twiddle(g, W_INV, Q));
  end

  // Butterfly addressing for stage s, butterfly k.
  always_comb begin
    h_c  = LOG_D'(1) << s_q;
    j_c  = ((k_q >> s_q) << (s_q + LOG_D'(1))) | (k_q & (h_c - LOG_D'(1)));
    jh_c = j_c + h_c;
    e_c  = (k_q & (h_c - LOG_D'(1))) << (LOG_D'(LOG_D - 1) - s_q);
    t_c  = mode_q ? tw_inv[e_c[LOG_D-2:0]] : tw_fwd[e_c[LOG_D-2:0]];
  end

  ntt_butterfly #(.N(N), .Q(Q)) u_bfly (
    .x      (arr_q[j_c]),
    .y      (arr_q[jh_c]),
    .t      (t_c),
    .sum_c  (sum_c),
    .diff_c (diff_c)
  );

  // Next-state, array update and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    s_d     = s_q;
    k_d     = k_q;
    arr_d   = arr_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < D; i++)
            arr_d[LOG_D'(bitrev(i, LOG_D))] = N'(modred(64'(a[N*i +: N]), 64'(Q)));
          mode_d  = mode;
          s_d     = '0;
          k_d     = '0;
          state_d = BFLY;
        end
      end
      BFLY: begin
        arr_d[j_c]  = sum_c;
        arr_d[jh_c] = diff_c;
        if (k_q == LOG_D'(HALF - 1)) begin
          k_d = '0;
          if (s_q == LOG_D'(LOG_D - 1)) begin
            s_d     = '0;
            state_d = mode_q ? SCALE : DONE;
          end else begin
            s_d = s_q + LOG_D'(1);
          end
        end else begin
          k_d = k_q + LOG_D'(1);
        end
      end
      SCALE: begin
        arr_d[k_q] = N'(modmul(64'(arr_q[k_q]), 64'(D_INV), 64'(Q)));
        if (k_q == LOG_D'(D - 1)) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + LOG_D'(1);
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    // out_valid rises one cycle after entering DONE and drops on handshake.
    out_valid_d = (state_q == DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      s_q         <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < D; i++) arr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      s_q         <= s_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      arr_q       <= arr_d;
    end
  end

  for (genvar g = 0; g < D; g++) begin : g_out
    assign b[N*g +: N] = arr_q[g];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ntt_iter.sv
// tb_ntt_iter: directed and round-trip checks of ntt_iter (D=16 default build
// and a D=8, Q=17 build sharing clock and reset).
module tb_ntt_iter;

  localparam int unsigned N   = 17;
  localparam int unsigned D   = 16;
  localparam int unsigned Q   = 65537;
  localparam int unsigned NB  = N * D;
  localparam int unsigned N8  = 5;
  localparam int unsigned D8  = 8;
  localparam int unsigned Q8  = 17;
  localparam int unsigned NB8 = N8 * D8;

  logic           clk, rst;
  logic           mode, in_valid, in_ready, out_valid, out_ready;
  logic [NB-1:0]  a, b;
  logic           mode8, in_valid8, in_ready8, out_valid8, out_ready8;
  logic [NB8-1:0] a8, b8;

  int total = 0;
  int bad   = 0;

  ntt_iter dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .out_valid(out_valid), .out_ready(out_ready), .b(b)
  );

  ntt_iter #(.N(N8), .D(D8), .Q(Q8), .W(9), .W_INV(2), .D_INV(15)) dut8 (
    .clk(clk), .rst(rst), .mode(mode8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .out_valid(out_valid8), .out_ready(out_ready8), .b(b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          md;
    logic [NB-1:0] av;
    logic [NB-1:0] ev;
    int            lat;
  } vec_t;

  task automatic chk(input string nm, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] fill(input int unsigned v);
    logic [NB-1:0] r;
    for (int i = 0; i < D; i++) r[N*i +: N] = N'(v);
    return r;
  endfunction

  // Caller sits just after a rising edge. Accept edge is lat=0.
  task automatic xfer16(input logic m, input logic [NB-1:0] av,
                        output logic [NB-1:0] bv, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    mode = m; a = av; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; mode = ~m; a = ~av;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    bv = b;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic xfer8(input logic m, input logic [NB8-1:0] av,
                       output logic [NB8-1:0] bv, output int lat);
    int w;
    w = 0;
    while (!in_ready8 && w < 100) begin @(posedge clk); #1; w++; end
    mode8 = m; a8 = av; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; mode8 = ~m;
    lat = 0;
    while (!out_valid8 && lat < 200) begin @(posedge clk); #1; lat++; end
    bv = b8;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    vec_t          vecs[7];
    int unsigned   p4[16];
    logic [NB-1:0] res, res2, orig, snap, ones_res;
    logic [NB8-1:0] r8, f8, o8;
    int            lat, lat2, w;
    logic          ok;

    p4 = '{1, 4, 16, 64, 256, 1024, 4096, 16384, 65536, 65533, 65521, 65473,
           65281, 64513, 61441, 49153};

    vecs[0] = '{1'b0, fill(1), '0, 33};
    vecs[0].ev[N-1:0] = N'(16);
    vecs[1] = '{1'b0, '0, fill(1), 33};
    vecs[1].av[N-1:0] = N'(1);
    vecs[2] = '{1'b0, '0, '0, 33};
    vecs[2].av[N +: N] = N'(1);
    for (int i = 0; i < D; i++) vecs[2].ev[N*i +: N] = N'(p4[i]);
    vecs[3] = '{1'b1, '0, fill(1), 49};
    vecs[3].av[N-1:0] = N'(16);
    vecs[4] = '{1'b1, fill(1), '0, 49};
    vecs[4].ev[N-1:0] = N'(1);
    vecs[5] = '{1'b0, '0, fill(1), 33};
    vecs[5].av[N-1:0] = N'(65538);
    vecs[6] = '{1'b0, '0, fill(65536), 33};
    vecs[6].av[N-1:0] = N'(65536);

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0;
    mode8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_in_ready", NB'(in_ready), NB'(1));
    chk("reset_out_valid", NB'(out_valid), '0);
    chk("reset_b", b, '0);

    // Directed table.
    for (int v = 0; v < 7; v++) begin
      xfer16(vecs[v].md, vecs[v].av, res, lat);
      chk($sformatf("vec%0d_b", v), res, vecs[v].ev);
      chk($sformatf("vec%0d_lat", v), NB'(lat), NB'(vecs[v].lat));
    end

    // Backpressure: hold the all-ones result, pending input must wait.
    mode = 1'b0; a = fill(1); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("bp_lat", NB'(lat), NB'(33));
    chk("bp_b", b, vecs[0].ev);
    snap = vecs[0].ev;
    a = '0; a[N-1:0] = N'(1); mode = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_b%0d", c), b, snap);
      chk($sformatf("bp_hold_in_ready%0d", c), NB'(in_ready), '0);
      chk($sformatf("bp_hold_out_valid%0d", c), NB'(out_valid), NB'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_in_ready", NB'(in_ready), NB'(1));
    chk("bp_idle_out_valid", NB'(out_valid), '0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", NB'(in_ready), '0);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("bp_second_lat", NB'(lat), NB'(33));
    chk("bp_second_b", b, fill(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a transform.
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    mode = 1'b0; a = fill(1); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_in_ready", NB'(in_ready), NB'(1));
    chk("rst_mid_out_valid", NB'(out_valid), '0);
    chk("rst_mid_b", b, '0);
    ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) ok = 1'b0;
    end
    chk("rst_mid_no_pulse", NB'(ok), NB'(1));
    xfer16(1'b0, fill(1), ones_res, lat);
    chk("rst_after_b", ones_res, vecs[0].ev);
    chk("rst_after_lat", NB'(lat), NB'(33));

    // Round trip NTT -> INTT, D=16.
    for (int v = 0; v < 100; v++) begin
      for (int i = 0; i < D; i++) orig[N*i +: N] = N'($urandom_range(Q - 1, 0));
      xfer16(1'b0, orig, res, lat);
      ok = 1'b1;
      for (int i = 0; i < D; i++) begin
        snap = '0;
        snap[N-1:0] = res[N*i +: N];
        if (snap >= NB'(Q)) ok = 1'b0;
      end
      chk($sformatf("rt%0d_range", v), NB'(ok), NB'(1));
      xfer16(1'b1, res, res2, lat2);
      chk($sformatf("rt%0d_b", v), res2, orig);
      chk($sformatf("rt%0d_lat", v), NB'({lat, lat2}), NB'({32'd33, 32'd49}));
    end

    // D=8, Q=17 build: delta and round trip.
    o8 = '0; o8[N8-1:0] = N8'(1);
    xfer8(1'b0, o8, r8, lat);
    for (int i = 0; i < D8; i++) f8[N8*i +: N8] = N8'(1);
    chk("d8_delta_b", NB'(r8), NB'(f8));
    chk("d8_delta_lat", NB'(lat), NB'(13));
    for (int v = 0; v < 20; v++) begin
      for (int i = 0; i < D8; i++) o8[N8*i +: N8] = N8'($urandom_range(Q8 - 1, 0));
      xfer8(1'b0, o8, f8, lat);
      xfer8(1'b1, f8, r8, lat2);
      chk($sformatf("d8_rt%0d_b", v), NB'(r8), NB'(o8));
      chk($sformatf("d8_rt%0d_lat", v), NB'({lat, lat2}), NB'({32'd13, 32'd21}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
